imem_loader: RTL
================

Name: imem_loader

Overview:
Byte-addressed instruction memory for the Y86-64 pipeline, together with its write side. A streaming byte loader accepts program segments of the form base address followed by payload bytes, and writes them into the memory. A registered read port returns the 10-byte instruction window the fetch stage decodes. This block replaces hard-coded program images and is the producer end of the fetch stage's instruction-memory interface.

Parameters:
MEM_BYTES, 2048, instruction memory size in bytes; a power of two no larger than 65536.
ADDR_W, 11, log2(MEM_BYTES); number of base-address bits used.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
load_valid  in  1  a load byte is presented.
load_ready  out  1  loader can accept a byte this cycle.
load_data  in  8  load byte.
load_last  in  1  marks the final byte of a segment.
prog_loaded  out  1  at least one segment has completed; sticky.
load_err  out  1  sticky load error.
bytes_written  out  16  count of payload bytes actually written to memory.
rd_en  in  1  fetch read request.
rd_addr  in  64  fetch PC.
rd_valid  out  1  read response valid.
rd_inst  out  80  instruction window; mem[rd_addr] is in bits [79:72], mem[rd_addr+9] is in bits [7:0].
rd_imem_er  out  1  rd_addr is out of range.

Behaviour:
- Reset (asynchronous, rst=1):
  - State goes to ADDR_HI.
  - load_ready=1, prog_loaded=0, load_err=0, bytes_written=0.
  - rd_valid=0, rd_inst=0, rd_imem_er=0.
  - Memory contents are not cleared.
  - Reset during a segment abandons it; bytes already written stay in memory.
- Handshake: a byte transfers on a rising edge where load_valid && load_ready. load_data and load_last must stay stable while load_valid=1 and load_ready=0.
- Loader state machine:
  - ADDR_HI: transfer captures addr[15:8]; go to ADDR_LO. load_ready=1.
  - ADDR_LO: transfer captures addr[7:0]; go to DATA. The write pointer becomes {hi,lo} masked to ADDR_W bits. load_ready=1.
  - DATA: each transfer writes load_data to mem[wptr], then wptr increments and bytes_written increments (16-bit, wraps).
    - If load_last=1, go to DONE.
    - If the unmasked {hi,lo} base plus the byte offset is ≥ MEM_BYTES, the byte is dropped: no write, no count, load_err set. The pointer never wraps into low memory.
  - DONE: load_ready=0 for exactly one cycle. prog_loaded becomes 1. Next state is ADDR_HI, ready for another segment.
  - load_last=1 on an ADDR_HI or ADDR_LO byte: the segment aborts, load_err is set, state returns to ADDR_HI, and nothing is written.
- Read port:
  - One-cycle latency. rd_en sampled at edge N gives rd_valid=1 after edge N, with rd_inst and rd_imem_er for that address.
  - rd_valid=0 in any cycle following an edge where rd_en=0. rd_inst holds its last value.
  - rd_imem_er=1 iff rd_addr ≥ MEM_BYTES; rd_inst is then 0.
  - When rd_addr is in range, window bytes whose address is ≥ MEM_BYTES read as 0x00.
  - Reads are permitted in every loader state; there is no stall.
  - Read and write to the same byte on the same edge: the read returns the old byte (read-before-write).
- Every cycle is independent: one read and one write per edge at most.

Test Plan:
- Reset, then load segment hi=0x00, lo=0x00, payload 30 F0 00 00 00 00 00 00 00 04 with load_last on the final byte -> bytes_written=10; load_ready low one cycle after last; prog_loaded=1. Read addr 0 -> next cycle rd_valid=1, rd_inst=0x30F00000000000000004, rd_imem_er=0.
- Load a second segment at base 0x0017 with payload 60 03 -> read addr 0x17 returns 0x6003 in [79:64]; bytes from the first segment are unchanged.
- Load at base 0x07FE with payload AA BB CC -> AA and BB written, CC dropped; load_err=1; bytes_written +2. Read addr 0x7FE returns 0xAABB followed by 0x00s. Read addr 0x800 -> rd_imem_er=1, rd_inst=0.
- load_valid toggled randomly with a 1-cycle DONE gap between segments -> no bytes lost or duplicated; final memory matches the golden image.
- Write 0x10 to addr 5 while rd_en with rd_addr=5 on the same edge -> rd_inst[79:72] is the old byte; a read the next cycle returns 0x10.
- Assert rst mid-DATA after 3 of 6 bytes -> outputs return to reset values immediately; the 3 bytes persist; a new segment loads normally starting from ADDR_HI.

Source files
------------

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - Y86-64 instruction memory with a streaming segment loader
// and a registered 10-byte fetch window.
module imem_loader #(
    parameter int MEM_BYTES = 2048,
    parameter int ADDR_W    = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [7:0]  load_data,
    input  logic        load_last,
    output logic        prog_loaded,
    output logic        load_err,
    output logic [15:0] bytes_written,
    input  logic        rd_en,
    input  logic [63:0] rd_addr,
    output logic        rd_valid,
    output logic [79:0] rd_inst,
    output logic        rd_imem_er
);

    localparam logic [1:0] ST_ADDR_HI = 2'd0;
    localparam logic [1:0] ST_ADDR_LO = 2'd1;
    localparam logic [1:0] ST_DATA    = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [16:0]     MEM_LIMIT = 17'(MEM_BYTES);
    localparam logic [ADDR_W:0] WIN_LIMIT = (ADDR_W + 1)'(MEM_BYTES);

    logic [1:0]        state;
    logic [7:0]        addr_hi;
    // Unmasked base+offset; it stops advancing once it reaches MEM_BYTES so the
    // write pointer can never wrap back into low memory.
    logic [16:0]       uptr;
    logic [ADDR_W-1:0] wptr;
    logic              xfer;
    logic              in_range;
    logic              wr_en;

    logic [7:0]        mem [MEM_BYTES];

    logic              rd_oob;
    logic [79:0]       window;

    assign load_ready = (state != ST_DONE);
    assign xfer       = load_valid && load_ready;
    assign in_range   = (uptr < MEM_LIMIT);
    assign wptr       = uptr[ADDR_W-1:0];
    assign wr_en      = xfer && (state == ST_DATA) && in_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_ADDR_HI;
            addr_hi       <= 8'h00;
            uptr          <= 17'd0;
            prog_loaded   <= 1'b0;
            load_err      <= 1'b0;
            bytes_written <= 16'd0;
        end else begin
            case (state)
                ST_ADDR_HI: begin
                    if (xfer) begin
                        if (load_last) begin
                            load_err <= 1'b1;
                        end else begin
                            addr_hi <= load_data;
                            state   <= ST_ADDR_LO;
                        end
                    end
                end
                ST_ADDR_LO: begin
                    if (xfer) begin
                        if (load_last) begin
                            load_err <= 1'b1;
                            state    <= ST_ADDR_HI;
                        end else begin
                            uptr  <= {1'b0, addr_hi, load_data};
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        if (in_range) begin
                            uptr          <= uptr + 17'd1;
                            bytes_written <= bytes_written + 16'd1;
                        end else begin
                            load_err <= 1'b1;
                        end
                        if (load_last) begin
                            state       <= ST_DONE;
                            prog_loaded <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_ADDR_HI;
                end
                default: begin
                    state <= ST_ADDR_HI;
                end
            endcase
        end
    end

    // Storage is deliberately outside the reset domain: contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= load_data;
        end
    end

    assign rd_oob = (rd_addr >= 64'(MEM_BYTES));

    always_comb begin
        logic [ADDR_W:0] win_addr;
        window   = 80'd0;
        win_addr = '0;
        for (int i = 0; i < 10; i++) begin
            win_addr = {1'b0, rd_addr[ADDR_W-1:0]} + (ADDR_W + 1)'(i);
            if (win_addr < WIN_LIMIT) begin
                window[79 - 8*i -: 8] = mem[win_addr[ADDR_W-1:0]];
            end
        end
    end

    // Nonblocking write above means a same-edge read sees the old byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid   <= 1'b0;
            rd_inst    <= 80'd0;
            rd_imem_er <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_imem_er <= rd_oob;
                rd_inst    <= rd_oob ? 80'd0 : window;
            end
        end
    end

endmodule
